jtframe_linedbl: RTL and testbench
==================================

// Module: jtframe_linedbl
// PURPOSE
//  Line doubler placed directly after jtframe_hsize. Converts the horizontally scaled
//  15 kHz stream (pxl_cen rate) into a 31 kHz stream (pxl2_cen rate) by emitting each
//  stored line twice, with optional scanline darkening on the second copy.
//  Output latency is one input line. The block feeds the VGA/HDMI output mux.
// PARAMETERS
//  COLORW  4  bits per colour channel
//  VW      9  line address width; max 2^VW pixels per line, blanking included
// PORTS
//  clk       in   1         system clock
//  rst       in   1         synchronous, active-high reset
//  pxl_cen   in   1         input pixel enable
//  pxl2_cen  in   1         output pixel enable; 2x pxl_cen, coincident with every pxl_cen
//  enable    in   1         1 = double, 0 = registered bypass
//  sl_mode   in   2         scanline level for the second copy: 0 off, 1 75%, 2 50%, 3 25%
//  r_in,g_in,b_in in COLORW input colour (hsize output)
//  HS_in,VS_in,HB_in,VB_in in 1  input syncs and blanks, active high
//  r_out,g_out,b_out out COLORW doubled colour
//  HS_out,VS_out,HB_out,VB_out out 1  doubled-rate syncs and blanks, active high
// BEHAVIOUR
//  Reset: all outputs 0; wrcnt, rdcnt, bank, copy, valid all 0; hmax, hsw, hb0, hb1 all 0.
//  Write side (pxl_cen):
//   - HSl <= HS_in; hsedge = HS_in & ~HSl.
//   - On hsedge: bank toggles, hmax <= wrcnt, wrcnt <= 0, vs_l <= VS_in, vb_l <= VB_in,
//     valid <= (hmax!=0).
//   - Otherwise wrcnt increments and saturates at 2^VW-1 (no wrap).
//   - hsw counts pxl_cen cycles while HS_in=1 and is latched when HS_in falls.
//   - hb1 <= wrcnt on the HB_in rising edge; hb0 <= wrcnt on the HB_in falling edge.
//   - Every pxl_cen writes {r,g,b} to RAM[{bank,wrcnt}].
//  Read side (pxl2_cen):
//   - Reads RAM[{~bank,rdcnt}] (previous line). RAM read latency is 1 clk.
//     Sync and blank outputs are delayed to match it.
//   - hsedge on the same clk: rdcnt <= 0, copy <= 0. This resync overrides wrap.
//   - Else if rdcnt==hmax: rdcnt <= 0, copy <= 1.
//   - Else rdcnt++.
//   - HS_out = 1 while rdcnt < hsw. Pulse length is the input pulse count in pxl2 ticks,
//     i.e. half the input duration.
//   - HB_out: set when rdcnt==hb1, cleared when rdcnt==hb0. Evaluated on both copies.
//   - VS_out, VB_out update at each output line start (rdcnt==0) from vs_l and vb_l.
//     Result: one input line of delay, and each VS line lasts two output lines.
//   - Colour: copy=0 gives raw data. copy=1 with sl_mode gives c - (c>>2), c>>1, or c>>2
//     for modes 1, 2, 3. Arithmetic is per channel, unsigned, in COLORW bits, no overflow.
//   - Colour is forced to 0 when HB_out=1 or valid=0.
//  Boundaries:
//   - First line after reset: valid=0, so output is black. HS_out and HB_out are still
//     generated from stored values.
//   - Input line longer than 2*(hmax+1) output ticks: the second copy wraps into a third
//     partial copy (copy stays 1) until hsedge resyncs.
//   - Input line shorter than expected: hsedge truncates the second copy; no stall.
//   - hmax saturated at 2^VW-1: line wraps inside the RAM bank, no corruption of the other bank.
//   - enable=0: on pxl_cen, every output is registered directly from its input.
//     Counters keep running, so re-enabling takes effect at the next hsedge.
//   - enable change mid-line is allowed; outputs may glitch for at most one line.
//   - rst mid-line: state is cleared that clk and the output is black until valid is set again.
// TESTING
//  - Line of 384 pxl_cen, HS 32 wide, ramp data r=wrcnt[3:0], sl_mode=0
//    -> from the 3rd line, each line appears twice; output HS is 32 pxl2 ticks, twice per input line.
//  - Same stream, sl_mode=2, r=4'hF -> first copy F, second copy 7; sl_mode=1 -> C; sl_mode=3 -> 3.
//  - HB high for wrcnt 256..383 -> HB_out high for rdcnt 256..383 on both copies; colour 0 there.
//  - Input line shortened from 384 to 380 pxl_cen -> resync at hsedge, rdcnt=0, copy=0; no X, no hang.
//  - VS_in high for 3 input lines -> VS_out high for 6 output lines, starting one input line later.
//  - enable=0 -> outputs equal inputs delayed by 1 pxl_cen; assert rst mid-line -> all outputs 0 the next clk.

Source files
------------

// File: rtl/jtframe_linedbl.sv
// Line doubler: stores each input line in one bank of a two-bank RAM while the previous
// line is replayed twice at pxl2_cen rate, the second copy optionally darkened.
module jtframe_linedbl #(
  parameter int COLORW = 4,
  parameter int VW     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic              pxl2_cen,
  input  logic              enable,
  input  logic [1:0]        sl_mode,
  input  logic [COLORW-1:0] r_in,
  input  logic [COLORW-1:0] g_in,
  input  logic [COLORW-1:0] b_in,
  input  logic              HS_in,
  input  logic              VS_in,
  input  logic              HB_in,
  input  logic              VB_in,
  output logic [COLORW-1:0] r_out,
  output logic [COLORW-1:0] g_out,
  output logic [COLORW-1:0] b_out,
  output logic              HS_out,
  output logic              VS_out,
  output logic              HB_out,
  output logic              VB_out
);
  localparam int DW = 3*COLORW;
  localparam logic [VW-1:0] CMAX = '1;

  logic [DW-1:0] ram [0:(2**(VW+1))-1];
  logic [DW-1:0] rd_q;

  logic          hsl_q, hsl_d, hbl_q, hbl_d, bank_q, bank_d;
  logic          vsl_q, vsl_d, vbl_q, vbl_d, valid_q, valid_d, copy_q, copy_d;
  logic [VW-1:0] wrcnt_q, wrcnt_d, rdcnt_q, rdcnt_d, hmax_q, hmax_d;
  logic [VW-1:0] hscnt_q, hscnt_d, hsw_q, hsw_d, hb0_q, hb0_d, hb1_q, hb1_d;
  logic          hbst_q, hbst_d, vsst_q, vsst_d, vbst_q, vbst_d;
  logic          s_hs_q, s_hs_d, s_hb_q, s_hb_d, s_vs_q, s_vs_d, s_vb_q, s_vb_d;
  logic          s_copy_q, s_copy_d, s_blank_q, s_blank_d;
  logic [COLORW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
  logic          hsedge;

  function automatic logic [COLORW-1:0] shade(input logic [COLORW-1:0] c, input logic [1:0] m);
    case (m)
      2'd1:    shade = c - (c >> 2);
      2'd2:    shade = c >> 1;
      2'd3:    shade = c >> 2;
      default: shade = c;
    endcase
  endfunction

  // Write and read always target opposite banks, so a saturated line only wraps in its own bank.
  always_ff @(posedge clk) begin
    if (pxl_cen) ram[{bank_q, wrcnt_q}] <= {r_in, g_in, b_in};
    if (pxl2_cen) rd_q <= ram[{~bank_q, rdcnt_q}];
  end

  always_comb begin
    hsl_d = hsl_q; hbl_d = hbl_q; bank_d = bank_q; vsl_d = vsl_q; vbl_d = vbl_q;
    valid_d = valid_q; copy_d = copy_q; wrcnt_d = wrcnt_q; rdcnt_d = rdcnt_q;
    hmax_d = hmax_q; hscnt_d = hscnt_q; hsw_d = hsw_q; hb0_d = hb0_q; hb1_d = hb1_q;
    hbst_d = hbst_q; vsst_d = vsst_q; vbst_d = vbst_q;
    s_hs_d = s_hs_q; s_hb_d = s_hb_q; s_vs_d = s_vs_q; s_vb_d = s_vb_q;
    s_copy_d = s_copy_q; s_blank_d = s_blank_q;
    r_d = r_q; g_d = g_q; b_d = b_q; hs_d = hs_q; vs_d = vs_q; hb_d = hb_q; vb_d = vb_q;
    hsedge = pxl_cen & HS_in & ~hsl_q;

    if (pxl_cen) begin
      hsl_d = HS_in;
      hbl_d = HB_in;
      if (hsedge) begin
        bank_d  = ~bank_q;
        hmax_d  = wrcnt_q;
        wrcnt_d = '0;
        vsl_d   = VS_in;
        vbl_d   = VB_in;
        valid_d = hmax_q != '0;
      end else if (wrcnt_q != CMAX) begin
        wrcnt_d = wrcnt_q + 1'b1;
      end
      if (hsedge)      hscnt_d = VW'(1);
      else if (HS_in)  hscnt_d = hscnt_q + 1'b1;
      if (!HS_in && hsl_q)  hsw_d = hscnt_q;
      if (HB_in && !hbl_q)  hb1_d = wrcnt_q;
      if (!HB_in && hbl_q)  hb0_d = wrcnt_q;
    end

    if (pxl2_cen) begin
      // Input hsync always wins so a short input line cuts the replay instead of stalling
      if (hsedge) begin
        rdcnt_d = '0;
        copy_d  = 1'b0;
      end else if (rdcnt_q == hmax_q) begin
        rdcnt_d = '0;
        copy_d  = 1'b1;
      end else begin
        rdcnt_d = rdcnt_q + 1'b1;
      end
      if (rdcnt_q == hb1_q)      hbst_d = 1'b1;
      else if (rdcnt_q == hb0_q) hbst_d = 1'b0;
      if (rdcnt_q == '0) begin
        vsst_d = vsl_q;
        vbst_d = vbl_q;
      end
      // Stage registers line up with the one-clock RAM read
      s_hs_d    = rdcnt_q < hsw_q;
      s_hb_d    = hbst_d;
      s_vs_d    = vsst_d;
      s_vb_d    = vbst_d;
      s_copy_d  = copy_q;
      s_blank_d = hbst_d | ~valid_q;
    end

    if (!enable) begin
      if (pxl_cen) begin
        r_d = r_in; g_d = g_in; b_d = b_in;
        hs_d = HS_in; vs_d = VS_in; hb_d = HB_in; vb_d = VB_in;
      end
    end else if (pxl2_cen) begin
      r_d = rd_q[DW-1 -: COLORW];
      g_d = rd_q[2*COLORW-1 -: COLORW];
      b_d = rd_q[COLORW-1:0];
      if (s_copy_q) begin
        r_d = shade(r_d, sl_mode);
        g_d = shade(g_d, sl_mode);
        b_d = shade(b_d, sl_mode);
      end
      if (s_blank_q) begin
        r_d = '0; g_d = '0; b_d = '0;
      end
      hs_d = s_hs_q; vs_d = s_vs_q; hb_d = s_hb_q; vb_d = s_vb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsl_q <= 1'b0; hbl_q <= 1'b0; bank_q <= 1'b0; vsl_q <= 1'b0; vbl_q <= 1'b0;
      valid_q <= 1'b0; copy_q <= 1'b0; wrcnt_q <= '0; rdcnt_q <= '0; hmax_q <= '0;
      hscnt_q <= '0; hsw_q <= '0; hb0_q <= '0; hb1_q <= '0;
      hbst_q <= 1'b0; vsst_q <= 1'b0; vbst_q <= 1'b0;
      s_hs_q <= 1'b0; s_hb_q <= 1'b0; s_vs_q <= 1'b0; s_vb_q <= 1'b0;
      s_copy_q <= 1'b0; s_blank_q <= 1'b0;
      r_q <= '0; g_q <= '0; b_q <= '0; hs_q <= 1'b0; vs_q <= 1'b0; hb_q <= 1'b0; vb_q <= 1'b0;
    end else begin
      hsl_q <= hsl_d; hbl_q <= hbl_d; bank_q <= bank_d; vsl_q <= vsl_d; vbl_q <= vbl_d;
      valid_q <= valid_d; copy_q <= copy_d; wrcnt_q <= wrcnt_d; rdcnt_q <= rdcnt_d;
      hmax_q <= hmax_d; hscnt_q <= hscnt_d; hsw_q <= hsw_d; hb0_q <= hb0_d; hb1_q <= hb1_d;
      hbst_q <= hbst_d; vsst_q <= vsst_d; vbst_q <= vbst_d;
      s_hs_q <= s_hs_d; s_hb_q <= s_hb_d; s_vs_q <= s_vs_d; s_vb_q <= s_vb_d;
      s_copy_q <= s_copy_d; s_blank_q <= s_blank_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d; hs_q <= hs_d; vs_q <= vs_d; hb_q <= hb_d; vb_q <= vb_d;
    end
  end

  assign r_out  = r_q;
  assign g_out  = g_q;
  assign b_out  = b_q;
  assign HS_out = hs_q;
  assign VS_out = vs_q;
  assign HB_out = hb_q;
  assign VB_out = vb_q;
endmodule

// File: tb/tb_jtframe_linedbl.sv
// Directed bench for jtframe_linedbl: ramp/flat lines, scanline levels, blanking,
// short-line resync, vertical sync doubling, bypass and mid-line reset.
module tb_jtframe_linedbl;
  logic       clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, pxl2_cen = 1'b0, enable = 1'b1;
  logic [1:0] sl_mode = 2'd0;
  logic [3:0] r_in = '0, g_in = '0, b_in = '0;
  logic       HS_in = 1'b0, VS_in = 1'b0, HB_in = 1'b0, VB_in = 1'b0;
  logic [3:0] r_out, g_out, b_out;
  logic       HS_out, VS_out, HB_out, VB_out;

  int n_cmp = 0, n_bad = 0;
  int prevlen = 384;
  logic [11:0] obs_rgb [0:767];
  logic        obs_hs [0:767], obs_hb [0:767], obs_vs [0:767], obs_vb [0:767];

  always #5 clk = ~clk;

  jtframe_linedbl #(.COLORW(4), .VW(9)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen), .enable(enable),
    .sl_mode(sl_mode), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .HS_in(HS_in), .VS_in(VS_in), .HB_in(HB_in), .VB_in(VB_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .HS_out(HS_out), .VS_out(VS_out), .HB_out(HB_out), .VB_out(VB_out));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int k);
    #1;
    obs_rgb[k] = {r_out, g_out, b_out};
    obs_hs[k] = HS_out; obs_hb[k] = HB_out; obs_vs[k] = VS_out; obs_vb[k] = VB_out;
  endtask

  // One input pixel = two clocks: pxl_cen+pxl2_cen, then pxl2_cen only.
  // Written data mirrors the write counter: r=w[3:0] (or F), g=w[7:4], b=9.
  task automatic pix(input int i, input bit fm, input bit vs);
    int w;
    w = (i == 0) ? prevlen - 1 : i - 1;
    @(negedge clk);
    HS_in = (i < 32); HB_in = (w >= 256); VS_in = vs; VB_in = vs;
    r_in = fm ? 4'hF : w[3:0]; g_in = w[7:4]; b_in = 4'h9;
    pxl_cen = 1'b1; pxl2_cen = 1'b1;
    @(posedge clk); sample(2*i);
    @(negedge clk); pxl_cen = 1'b0;
    @(posedge clk); sample(2*i+1);
  endtask

  task automatic run_line(input int len, input bit fm, input bit vs, input logic [1:0] slm);
    sl_mode = slm;
    for (int i = 0; i < len; i++) pix(i, fm, vs);
    prevlen = len;
  endtask

  function automatic logic [3:0] shade_m(input int c, input int slm);
    case (slm)
      1: return 4'(c - c/4);
      2: return 4'(c/2);
      3: return 4'(c/4);
      default: return 4'(c);
    endcase
  endfunction

  function automatic logic [11:0] exp_rgb(input int rd, input bit cp, input int slm, input bit fm);
    int rr, gg, bb;
    if (rd >= 256) return 12'h000;
    rr = fm ? 15 : rd % 16; gg = (rd / 16) % 16; bb = 9;
    if (cp) return {shade_m(rr, slm), shade_m(gg, slm), shade_m(bb, slm)};
    return {4'(rr), 4'(gg), 4'(bb)};
  endfunction

  // Output tick o = k-2 shows rdcnt = o % len on copy (o >= len).
  task automatic check_line(input int ln, input int len, input int kmax, input int slm, input bit fm);
    for (int k = 2; k <= kmax; k++) begin
      int o, rd;
      bit cp;
      o = k - 2; rd = o % len; cp = (o >= len);
      chk($sformatf("L%0d_rgb_o%0d", ln, o), 32'(obs_rgb[k]), 32'(exp_rgb(rd, cp, slm, fm)));
      chk($sformatf("L%0d_hs_o%0d", ln, o), 32'(obs_hs[k]), 32'(rd < 32));
      chk($sformatf("L%0d_hb_o%0d", ln, o), 32'(obs_hb[k]), 32'(rd >= 256));
    end
  endtask

  logic [15:0] byp_v [0:7] = '{16'hA5C_A, 16'h3F1_5, 16'h000_F, 16'hFFF_0,
                               16'h123_8, 16'h9E7_4, 16'h456_2, 16'hC3A_1};

  initial begin
    int nz, nhs, vs_starts, vb_starts;
    repeat (4) begin
      @(negedge clk); pxl_cen = ~pxl_cen; pxl2_cen = 1'b1;
    end
    @(negedge clk); pxl_cen = 1'b0; pxl2_cen = 1'b0;
    @(posedge clk); #1;
    chk("rst_rgb", 32'({r_out, g_out, b_out}), 32'h0);
    chk("rst_sync", 32'({HS_out, VS_out, HB_out, VB_out}), 32'h0);
    @(negedge clk); rst = 1'b0;

    run_line(384, 1'b0, 1'b0, 2'd0);
    run_line(384, 1'b0, 1'b0, 2'd0);
    nz = 0; nhs = 0;
    for (int k = 2; k < 768; k++) begin
      if (obs_rgb[k] != 12'h0) nz++;
      if (obs_hs[k]) nhs++;
    end
    chk("L1_black_count", 32'(nz), 32'd0);
    chk("L1_hs_ticks", 32'(nhs), 32'd64);

    run_line(384, 1'b0, 1'b0, 2'd0); check_line(2, 384, 767, 0, 1'b0);
    run_line(384, 1'b1, 1'b0, 2'd2); check_line(3, 384, 767, 2, 1'b0);
    run_line(384, 1'b1, 1'b0, 2'd2); check_line(4, 384, 767, 2, 1'b1);
    run_line(384, 1'b1, 1'b0, 2'd1); check_line(5, 384, 767, 1, 1'b1);
    run_line(384, 1'b0, 1'b0, 2'd3); check_line(6, 384, 767, 3, 1'b1);

    vs_starts = 32'(obs_vs[2]) + 32'(obs_vs[386]);
    vb_starts = 32'(obs_vb[2]) + 32'(obs_vb[386]);
    chk("L6_vs_pre", 32'(obs_vs[2]), 32'd0);
    for (int ln = 7; ln <= 11; ln++) begin
      run_line(384, 1'b0, (ln <= 9), 2'd0);
      vs_starts += 32'(obs_vs[2]) + 32'(obs_vs[386]);
      vb_starts += 32'(obs_vb[2]) + 32'(obs_vb[386]);
      if (ln == 9)  chk("L9_vs_copy2", 32'(obs_vs[386]), 32'd1);
      if (ln == 10) chk("L10_vs_off", 32'(obs_vs[2]), 32'd0);
    end
    chk("vs_out_lines", 32'(vs_starts), 32'd6);
    chk("vb_out_lines", 32'(vb_starts), 32'd6);

    run_line(380, 1'b0, 1'b0, 2'd0); check_line(12, 384, 759, 0, 1'b0);
    run_line(380, 1'b0, 1'b0, 2'd0); check_line(13, 380, 759, 0, 1'b0);

    enable = 1'b0;
    for (int n = 0; n < 8; n++) begin
      logic [15:0] v;
      v = byp_v[n];
      @(negedge clk);
      {r_in, g_in, b_in, HS_in, VS_in, HB_in, VB_in} = v;
      pxl_cen = 1'b1; pxl2_cen = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("byp_%0d", n), 32'({r_out, g_out, b_out, HS_out, VS_out, HB_out, VB_out}), 32'(v));
      @(negedge clk); pxl_cen = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("byp_hold_%0d", n), 32'({r_out, g_out, b_out, HS_out, VS_out, HB_out, VB_out}), 32'(v));
    end

    @(negedge clk);
    {r_in, g_in, b_in, HS_in, VS_in, HB_in, VB_in} = 16'hFFF_F;
    pxl_cen = 1'b1; pxl2_cen = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out", 32'({r_out, g_out, b_out, HS_out, VS_out, HB_out, VB_out}), 32'h0);

    @(negedge clk); rst = 1'b0; enable = 1'b1; pxl_cen = 1'b0;
    prevlen = 384;
    for (int i = 0; i < 40; i++) pix(i, 1'b1, 1'b0);
    nz = 0;
    for (int k = 0; k < 80; k++) if (obs_rgb[k] != 12'h0) nz++;
    chk("postrst_black", 32'(nz), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
